// File: rtl/controle_multiciclo_param.sv
// ----------------------------------------------------------------------------
// controle_multiciclo_param
//
// Multicycle MIPS control unit. A Moore-style FSM sequences the shared
// datapath (PC, IR, MDR, ALUOut, register file, memory, EPC) through fetch,
// a parametrised memory wait, decode and the per-instruction execute states.
// Every control output is a combinational decode of the current state; the
// only input-dependent outputs are the overflow write-kill in R_WRITE and
// ADDI_WRITE, and the final-count MDR write in LOAD_WAIT.
//
// Build option:
//   CTRL_EXCEPTION_EN  when defined, invalid opcodes and add/sub/addi overflow
//                      trap to EXC (EPC write, jump to exception vector).
//                      When undefined, EXC is unreachable, EscreveEPC/Causa
//                      are 0, invalid opcodes act as NOP and Overflow is
//                      ignored.
//
// Parameters:
//   MEM_WAIT        wait cycles after each memory read (1..15)
//   EXC_VECTOR_SEL  OrigPC code that selects the exception vector
//
// Ports:
//   clock, reset       clock; asynchronous active-high reset
//   OPcode, funct      IR[31:26], IR[5:0]
//   Overflow           ALU overflow flag
//   EscreveMem         memory write enable
//   EscrevePC          unconditional PC write
//   EscrevePCCondEQ/NE conditional PC write on zero / not zero
//   OrigPC             PC source select
//   RegDst             register destination select
//   EscreveReg         register file write enable
//   MemparaReg         register write-data select
//   IouD               memory address select
//   EscreveIR/MDR/AluOut/EPC  register write enables
//   OrigAALU, OrigBALU ALU operand selects
//   OpALU              ALU operation class
//   Causa              exception cause (0 invalid opcode, 1 overflow)
//   State              current state code
// ----------------------------------------------------------------------------
module controle_multiciclo_param #(
    parameter int unsigned MEM_WAIT       = 1,
    parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    output logic       EscreveMem,
    output logic       EscrevePC,
    output logic       EscrevePCCondEQ,
    output logic       EscrevePCCondNE,
    output logic [1:0] OrigPC,
    output logic [1:0] RegDst,
    output logic       EscreveReg,
    output logic [1:0] MemparaReg,
    output logic       IouD,
    output logic       EscreveIR,
    output logic       EscreveMDR,
    output logic       EscreveAluOut,
    output logic       OrigAALU,
    output logic [1:0] OrigBALU,
    output logic [1:0] OpALU,
    output logic       EscreveEPC,
    output logic       Causa,
    output logic [5:0] State
);

`ifdef CTRL_EXCEPTION_EN
    localparam bit ExcEn = 1'b1;
`else
    localparam bit ExcEn = 1'b0;
`endif

    typedef enum logic [5:0] {
        StReset     = 6'd0,
        StFetch     = 6'd1,
        StWait      = 6'd2,
        StIrWrite   = 6'd3,
        StDecode    = 6'd4,
        StRExec     = 6'd5,
        StRWrite    = 6'd6,
        StAddr      = 6'd7,
        StLoadRd    = 6'd8,
        StLoadWait  = 6'd9,
        StLoadWb    = 6'd10,
        StStore     = 6'd11,
        StBeq       = 6'd12,
        StBne       = 6'd13,
        StLui       = 6'd14,
        StJump      = 6'd15,
        StJal       = 6'd16,
        StJr        = 6'd17,
        StAddiExec  = 6'd18,
        StAddiWrite = 6'd19,
        StNop       = 6'd20,
        StBreak     = 6'd21,
        StExc       = 6'd22
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnNop   = 6'h00;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnBreak = 6'h0D;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;

    // Counter reload so that a wait phase spans exactly MEM_WAIT cycles
    // (the exit happens in the cycle the counter reads zero).
    localparam logic [3:0] WaitLoad = 4'(MEM_WAIT - 32'd1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cause_q, cause_d;
    logic       ovf_trap;

    // Overflow only traps the signed add/sub forms; addu/subu-style functs
    // and logical ops write back regardless.
    always_comb begin
        ovf_trap = 1'b0;
        if (ExcEn && Overflow) begin
            if (state_q == StRWrite && (funct == FnAdd || funct == FnSub)) begin
                ovf_trap = 1'b1;
            end else if (state_q == StAddiWrite) begin
                ovf_trap = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            StReset: begin
                state_d = StFetch;
            end
            StFetch: begin
                state_d = StWait;
                cnt_d   = WaitLoad;
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIrWrite;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StIrWrite: begin
                state_d = StDecode;
            end
            StDecode: begin
                unique case (OPcode)
                    OpRType: begin
                        unique case (funct)
                            FnBreak: state_d = StBreak;
                            FnNop:   state_d = StNop;
                            FnJr:    state_d = StJr;
                            default: state_d = StRExec;
                        endcase
                    end
                    OpJ:          state_d = StJump;
                    OpJal:        state_d = StJal;
                    OpBeq:        state_d = StBeq;
                    OpBne:        state_d = StBne;
                    OpAddi:       state_d = StAddiExec;
                    OpLui:        state_d = StLui;
                    OpLw, OpSw:   state_d = StAddr;
                    default: begin
                        if (ExcEn) begin
                            state_d = StExc;
                            cause_d = 1'b0;
                        end else begin
                            state_d = StNop;
                        end
                    end
                endcase
            end
            StRExec: begin
                state_d = StRWrite;
            end
            StAddiExec: begin
                state_d = StAddiWrite;
            end
            StRWrite, StAddiWrite: begin
                if (ovf_trap) begin
                    state_d = StExc;
                    cause_d = 1'b1;
                end else begin
                    state_d = StFetch;
                end
            end
            StAddr: begin
                // Dispatch on the opcode only: funct bits of an I-type word
                // are immediate data and must not steer the load/store choice.
                if (OPcode == OpLw) begin
                    state_d = StLoadRd;
                end else if (OPcode == OpSw) begin
                    state_d = StStore;
                end else begin
                    state_d = StFetch;
                end
            end
            StLoadRd: begin
                state_d = StLoadWait;
                cnt_d   = WaitLoad;
            end
            StLoadWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StLoadWb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBreak: begin
                state_d = StBreak;
            end
            default: begin
                // LoadWb, Store, branches, jumps, Lui, Nop, Exc and any
                // unencoded value all return to fetch.
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= 4'd0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        EscreveMem      = 1'b0;
        EscrevePC       = 1'b0;
        EscrevePCCondEQ = 1'b0;
        EscrevePCCondNE = 1'b0;
        OrigPC          = 2'b00;
        RegDst          = 2'b00;
        EscreveReg      = 1'b0;
        MemparaReg      = 2'b00;
        IouD            = 1'b0;
        EscreveIR       = 1'b0;
        EscreveMDR      = 1'b0;
        EscreveAluOut   = 1'b0;
        OrigAALU        = 1'b0;
        OrigBALU        = 2'b00;
        OpALU           = 2'b00;
        EscreveEPC      = 1'b0;
        Causa           = 1'b0;
        unique case (state_q)
            StFetch: begin
                // PC <= PC + 4 while the instruction read is issued.
                EscrevePC = 1'b1;
                OrigBALU  = 2'b01;
            end
            StIrWrite: begin
                EscreveIR = 1'b1;
            end
            StDecode: begin
                // Speculative branch target into ALUOut.
                OrigBALU      = 2'b11;
                EscreveAluOut = 1'b1;
            end
            StRExec: begin
                OrigAALU      = 1'b1;
                OpALU         = 2'b10;
                EscreveAluOut = 1'b1;
            end
            StRWrite: begin
                RegDst     = 2'b01;
                EscreveReg = !ovf_trap;
            end
            StAddiExec, StAddr: begin
                OrigAALU      = 1'b1;
                OrigBALU      = 2'b10;
                EscreveAluOut = 1'b1;
            end
            StAddiWrite: begin
                EscreveReg = !ovf_trap;
            end
            StLoadRd: begin
                IouD = 1'b1;
            end
            StLoadWait: begin
                IouD       = 1'b1;
                EscreveMDR = (cnt_q == 4'd0);
            end
            StLoadWb: begin
                MemparaReg = 2'b01;
                EscreveReg = 1'b1;
            end
            StStore: begin
                IouD       = 1'b1;
                EscreveMem = 1'b1;
            end
            StBeq: begin
                OrigAALU        = 1'b1;
                OpALU           = 2'b01;
                EscrevePCCondEQ = 1'b1;
                OrigPC          = 2'b01;
            end
            StBne: begin
                OrigAALU        = 1'b1;
                OpALU           = 2'b01;
                EscrevePCCondNE = 1'b1;
                OrigPC          = 2'b01;
            end
            StLui: begin
                MemparaReg = 2'b10;
                EscreveReg = 1'b1;
            end
            StJump: begin
                OrigPC    = 2'b10;
                EscrevePC = 1'b1;
            end
            StJal: begin
                RegDst     = 2'b10;
                MemparaReg = 2'b11;
                EscreveReg = 1'b1;
                OrigPC     = 2'b10;
                EscrevePC  = 1'b1;
            end
            StJr: begin
                // rs + $0 passes A straight through the adder.
                OrigAALU  = 1'b1;
                EscrevePC = 1'b1;
            end
            StExc: begin
                if (ExcEn) begin
                    // ALU computes PC-4, the address of the faulting word.
                    OrigBALU   = 2'b01;
                    OpALU      = 2'b01;
                    EscreveEPC = 1'b1;
                    EscrevePC  = 1'b1;
                    OrigPC     = EXC_VECTOR_SEL;
                    Causa      = cause_q;
                end
            end
            default: begin
                // Reset, Wait, Nop, Break: nothing asserted.
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_controle_multiciclo_param.sv
module tb_controle_multiciclo_param;

`ifdef CTRL_EXCEPTION_EN
    localparam bit ExcEn = 1'b1;
`else
    localparam bit ExcEn = 1'b0;
`endif

    localparam int MwA = 3;
    localparam int MwB = 1;

    typedef struct packed {
        logic [5:0] st;
        logic       mem, pc, ceq, cne;
        logic [1:0] opc, rdst;
        logic       wreg;
        logic [1:0] m2r;
        logic       iord, wir, wmdr, waluout, srca;
        logic [1:0] srcb, aluop;
        logic       wepc, causa;
    } ctl_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] OPcode, funct;
    logic       Overflow;

    logic       mem_a, pc_a, ceq_a, cne_a, wreg_a, iord_a, wir_a, wmdr_a, walu_a, srca_a;
    logic       wepc_a, causa_a;
    logic [1:0] opc_a, rdst_a, m2r_a, srcb_a, aluop_a;
    logic [5:0] st_a;
    logic       mem_b, pc_b, ceq_b, cne_b, wreg_b, iord_b, wir_b, wmdr_b, walu_b, srca_b;
    logic       wepc_b, causa_b;
    logic [1:0] opc_b, rdst_b, m2r_b, srcb_b, aluop_b;
    logic [5:0] st_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel      = 1'b0;
    ctl_t exp_q[$];

    always #5 clock = ~clock;

    controle_multiciclo_param #(.MEM_WAIT(MwA), .EXC_VECTOR_SEL(2'b11)) dut_a (
        .clock(clock), .reset(reset), .OPcode(OPcode), .funct(funct), .Overflow(Overflow),
        .EscreveMem(mem_a), .EscrevePC(pc_a), .EscrevePCCondEQ(ceq_a),
        .EscrevePCCondNE(cne_a), .OrigPC(opc_a), .RegDst(rdst_a), .EscreveReg(wreg_a),
        .MemparaReg(m2r_a), .IouD(iord_a), .EscreveIR(wir_a), .EscreveMDR(wmdr_a),
        .EscreveAluOut(walu_a), .OrigAALU(srca_a), .OrigBALU(srcb_a), .OpALU(aluop_a),
        .EscreveEPC(wepc_a), .Causa(causa_a), .State(st_a)
    );

    controle_multiciclo_param #(.MEM_WAIT(MwB), .EXC_VECTOR_SEL(2'b11)) dut_b (
        .clock(clock), .reset(reset), .OPcode(OPcode), .funct(funct), .Overflow(Overflow),
        .EscreveMem(mem_b), .EscrevePC(pc_b), .EscrevePCCondEQ(ceq_b),
        .EscrevePCCondNE(cne_b), .OrigPC(opc_b), .RegDst(rdst_b), .EscreveReg(wreg_b),
        .MemparaReg(m2r_b), .IouD(iord_b), .EscreveIR(wir_b), .EscreveMDR(wmdr_b),
        .EscreveAluOut(walu_b), .OrigAALU(srca_b), .OrigBALU(srcb_b), .OpALU(aluop_b),
        .EscreveEPC(wepc_b), .Causa(causa_b), .State(st_b)
    );

    function automatic ctl_t obs();
        ctl_t c;
        if (!sel) c = '{st_a, mem_a, pc_a, ceq_a, cne_a, opc_a, rdst_a, wreg_a, m2r_a, iord_a,
                        wir_a, wmdr_a, walu_a, srca_a, srcb_a, aluop_a, wepc_a, causa_a};
        else      c = '{st_b, mem_b, pc_b, ceq_b, cne_b, opc_b, rdst_b, wreg_b, m2r_b, iord_b,
                        wir_b, wmdr_b, walu_b, srca_b, srcb_b, aluop_b, wepc_b, causa_b};
        return c;
    endfunction

    // Expected control word of each state, as tabulated for the controller.
    function automatic ctl_t mk(input int st);
        ctl_t c = '0;
        c.st = 6'(st);
        case (st)
            1:  begin c.pc = 1; c.srcb = 2'b01; end
            3:  c.wir = 1;
            4:  begin c.srcb = 2'b11; c.waluout = 1; end
            5:  begin c.srca = 1; c.aluop = 2'b10; c.waluout = 1; end
            6:  begin c.rdst = 2'b01; c.wreg = 1; end
            7, 18: begin c.srca = 1; c.srcb = 2'b10; c.waluout = 1; end
            8, 9: c.iord = 1;
            10: begin c.m2r = 2'b01; c.wreg = 1; end
            11: begin c.iord = 1; c.mem = 1; end
            12: begin c.srca = 1; c.aluop = 2'b01; c.ceq = 1; c.opc = 2'b01; end
            13: begin c.srca = 1; c.aluop = 2'b01; c.cne = 1; c.opc = 2'b01; end
            14: begin c.m2r = 2'b10; c.wreg = 1; end
            15: begin c.opc = 2'b10; c.pc = 1; end
            16: begin c.rdst = 2'b10; c.m2r = 2'b11; c.wreg = 1; c.opc = 2'b10; c.pc = 1; end
            17: begin c.srca = 1; c.pc = 1; end
            19: c.wreg = 1;
            22: begin c.srcb = 2'b01; c.aluop = 2'b01; c.wepc = 1; c.pc = 1; c.opc = 2'b11; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check_eq(input string tag, input ctl_t got, input ctl_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ctl=%h, expected st=%0d ctl=%h",
                     tag, got.st, got, exp.st, exp);
        end
    endtask

    task automatic push_exc(input bit cause);
        ctl_t e = mk(22);
        e.causa = cause;
        exp_q.push_back(e);
    endtask

    // Queue the expected state/output trace of one instruction, then
    // retire it one entry per cycle. Entered and left on a falling edge
    // where the DUT is (expected to be) in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input int mw);
        ctl_t e;
        int   k;
        OPcode   = op;
        funct    = fn;
        Overflow = ovf;
        exp_q.push_back(mk(1));
        for (int i = 0; i < mw; i++) exp_q.push_back(mk(2));
        exp_q.push_back(mk(3));
        exp_q.push_back(mk(4));
        case (op)
            6'h00: begin
                if (fn == 6'h0D) begin
                    for (int i = 0; i < 3; i++) exp_q.push_back(mk(21));
                end else if (fn == 6'h00) begin
                    exp_q.push_back(mk(20));
                end else if (fn == 6'h08) begin
                    exp_q.push_back(mk(17));
                end else begin
                    exp_q.push_back(mk(5));
                    e = mk(6);
                    if (ExcEn && ovf && (fn == 6'h20 || fn == 6'h22)) begin
                        e.wreg = 0;
                        exp_q.push_back(e);
                        push_exc(1'b1);
                    end else begin
                        exp_q.push_back(e);
                    end
                end
            end
            6'h02: exp_q.push_back(mk(15));
            6'h03: exp_q.push_back(mk(16));
            6'h04: exp_q.push_back(mk(12));
            6'h05: exp_q.push_back(mk(13));
            6'h0F: exp_q.push_back(mk(14));
            6'h08: begin
                exp_q.push_back(mk(18));
                e = mk(19);
                if (ExcEn && ovf) begin
                    e.wreg = 0;
                    exp_q.push_back(e);
                    push_exc(1'b1);
                end else begin
                    exp_q.push_back(e);
                end
            end
            6'h23: begin
                exp_q.push_back(mk(7));
                exp_q.push_back(mk(8));
                for (int i = 0; i < mw; i++) begin
                    e = mk(9);
                    e.wmdr = (i == mw - 1);
                    exp_q.push_back(e);
                end
                exp_q.push_back(mk(10));
            end
            6'h2B: begin
                exp_q.push_back(mk(7));
                exp_q.push_back(mk(11));
            end
            default: begin
                if (ExcEn) push_exc(1'b0);
                else       exp_q.push_back(mk(20));
            end
        endcase
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            check_eq($sformatf("%s[%0d]", name, k), obs(), e);
            k++;
            @(negedge clock);
        end
    endtask

    // Hold reset for three cycles, checking the all-zero RESET word, and
    // leave on the falling edge where the DUT should have entered FETCH.
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check_eq($sformatf("reset[%0d]", i), obs(), mk(0));
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic reset_mid_wait();
        OPcode = 6'h00;
        funct  = 6'h20;
        #1;
        check_eq("rstwait_fetch", obs(), mk(1));
        @(negedge clock);
        #1;
        check_eq("rstwait_wait", obs(), mk(2));
        reset = 1'b1;
        #1;
        check_eq("rstwait_async", obs(), mk(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        OPcode   = 6'h00;
        funct    = 6'h00;
        Overflow = 1'b0;

        sel = 1'b0;
        do_reset();
        run_instr("add",      6'h00, 6'h20, 1'b0, MwA);
        run_instr("sub_ovf",  6'h00, 6'h22, 1'b1, MwA);
        run_instr("and_ovf",  6'h00, 6'h24, 1'b1, MwA);
        run_instr("lw",       6'h23, 6'h2B, 1'b0, MwA);
        run_instr("sw",       6'h2B, 6'h23, 1'b0, MwA);
        run_instr("beq",      6'h04, 6'h11, 1'b0, MwA);
        run_instr("bne",      6'h05, 6'h00, 1'b0, MwA);
        run_instr("lui",      6'h0F, 6'h3F, 1'b0, MwA);
        run_instr("j",        6'h02, 6'h08, 1'b0, MwA);
        run_instr("jal",      6'h03, 6'h0D, 1'b0, MwA);
        run_instr("jr",       6'h00, 6'h08, 1'b0, MwA);
        run_instr("nop",      6'h00, 6'h00, 1'b0, MwA);
        run_instr("addi",     6'h08, 6'h00, 1'b0, MwA);
        run_instr("addi_ovf", 6'h08, 6'h05, 1'b1, MwA);
        run_instr("bad_op",   6'h3F, 6'h20, 1'b0, MwA);
        reset_mid_wait();
        run_instr("add2",     6'h00, 6'h20, 1'b0, MwA);
        run_instr("break",    6'h00, 6'h0D, 1'b0, MwA);

        sel = 1'b1;
        do_reset();
        run_instr("b_lw",     6'h23, 6'h00, 1'b0, MwB);
        run_instr("b_sw",     6'h2B, 6'h23, 1'b0, MwB);
        run_instr("b_add",    6'h00, 6'h20, 1'b0, MwB);
        run_instr("b_bad_op", 6'h3F, 6'h00, 1'b0, MwB);
        run_instr("b_break",  6'h00, 6'h0D, 1'b0, MwB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo_param.md
Name: controle_multiciclo_param

Overview:
Parametrised multicycle MIPS control unit, successor to the fixed-timing controller. Drives the multicycle datapath: PC, IR, MDR, ALUOut, register file, memory and EPC. Generalised memory wait-state count. Adds ADDI, JAL and JR, a dedicated reset state, and optional overflow/invalid-opcode exception handling.

Parameters:
MEM_WAIT, 1, number of wait cycles after every memory read (legal range 1..15)
EXC_VECTOR_SEL, 2'b11, OrigPC code that selects the exception vector in the PC mux

Ports:
clock  in  1  system clock
reset  in  1  reset (already decided)
OPcode  in  6  IR[31:26], stable from IR_WRITE+1 onward
funct  in  6  IR[5:0]
Overflow  in  1  ALU overflow flag, combinational from current ALU operation
EscreveMem  out  1  memory write enable
EscrevePC  out  1  unconditional PC write
EscrevePCCondEQ  out  1  PC write if ALU zero
EscrevePCCondNE  out  1  PC write if ALU not zero
OrigPC  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
RegDst  out  2  00 rt, 01 rd, 10 $31
EscreveReg  out  1  register file write enable
MemparaReg  out  2  00 ALUOut, 01 MDR, 10 imm<<16, 11 PC
IouD  out  1  0 PC address, 1 ALUOut address
EscreveIR  out  1  IR write enable
EscreveMDR  out  1  MDR write enable
EscreveAluOut  out  1  ALUOut write enable
OrigAALU  out  1  0 PC, 1 A
OrigBALU  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
OpALU  out  2  00 add, 01 sub, 10 use funct
EscreveEPC  out  1  EPC write enable
Causa  out  1  exception cause: 0 invalid opcode, 1 overflow (valid only when EscreveEPC=1)
State  out  6  current state code

Behaviour:
- Reset is asynchronous and active-high. State is forced to RESET (code 0). Every output is 0 in RESET. On the first clock edge after reset deasserts, the FSM moves to FETCH.
- All outputs are a combinational decode of state. Any output not listed for a state is 0.
- State codes:
  - RESET=0, FETCH=1, WAIT=2, IR_WRITE=3, DECODE=4
  - R_EXEC=5, R_WRITE=6, ADDR=7, LOAD_RD=8, LOAD_WAIT=9, LOAD_WB=10, STORE=11
  - BEQ=12, BNE=13, LUI=14, JUMP=15, JAL=16, JR=17
  - ADDI_EXEC=18, ADDI_WRITE=19, NOP=20, BREAK=21, EXC=22
- FETCH: IouD=0, EscrevePC=1, OrigAALU=0, OrigBALU=01, OpALU=00, OrigPC=00 (PC <= PC+4). Next state is WAIT; the wait counter loads MEM_WAIT-1.
- WAIT: no outputs asserted. The counter decrements each cycle; at 0 the FSM goes to IR_WRITE. WAIT therefore lasts exactly MEM_WAIT cycles.
- IR_WRITE: EscreveIR=1. Next state is DECODE.
- DECODE: OrigAALU=0, OrigBALU=11, OpALU=00, EscreveAluOut=1 (branch target). Dispatch:
  - op 0x00, funct 0x0D -> BREAK; funct 0x00 -> NOP; funct 0x08 -> JR; other funct -> R_EXEC
  - op 0x02 -> JUMP; 0x03 -> JAL; 0x04 -> BEQ; 0x05 -> BNE
  - 0x08 -> ADDI_EXEC; 0x0F -> LUI; 0x23 or 0x2B -> ADDR
  - any other opcode -> EXC if CTRL_EXCEPTION_EN is defined, else NOP
- R_EXEC: OrigAALU=1, OrigBALU=00, OpALU=10, EscreveAluOut=1. Next state is R_WRITE.
- R_WRITE: RegDst=01, MemparaReg=00, EscreveReg=1. Next state is FETCH.
- ADDI_EXEC: OrigAALU=1, OrigBALU=10, OpALU=00, EscreveAluOut=1. Next state is ADDI_WRITE.
- ADDI_WRITE: RegDst=00, MemparaReg=00, EscreveReg=1. Next state is FETCH.
- ADDR: OrigAALU=1, OrigBALU=10, OpALU=00, EscreveAluOut=1. Next state is LOAD_RD if OPcode=0x23, STORE if 0x2B. The dispatch uses OPcode, never funct.
- LOAD_RD: IouD=1. Next state is LOAD_WAIT; the counter loads MEM_WAIT-1.
- LOAD_WAIT: IouD=1; EscreveMDR=1 only in the final count cycle. Next state is LOAD_WB.
- LOAD_WB: RegDst=00, MemparaReg=01, EscreveReg=1. Next state is FETCH.
- STORE: IouD=1, EscreveMem=1 for exactly one cycle. Next state is FETCH.
- BEQ: OrigAALU=1, OrigBALU=00, OpALU=01, EscrevePCCondEQ=1, OrigPC=01. Next state is FETCH.
- BNE: same outputs as BEQ but with EscrevePCCondNE=1 instead of EscrevePCCondEQ. Next state is FETCH.
- LUI: RegDst=00, MemparaReg=10, EscreveReg=1. Next state is FETCH.
- JUMP: OrigPC=10, EscrevePC=1. Next state is FETCH.
- JAL: RegDst=10, MemparaReg=11, EscreveReg=1, OrigPC=10, EscrevePC=1. Next state is FETCH.
- JR: OrigAALU=1, OrigBALU=00, OpALU=00 (A+B with rt=$0), OrigPC=00, EscrevePC=1. Next state is FETCH.
- NOP: no outputs asserted. Next state is FETCH.
- BREAK: no outputs asserted. Terminal; exited only by reset.
- EXC: OrigAALU=0, OrigBALU=01, OpALU=01 (ALU = PC-4), EscreveEPC=1, EscrevePC=1, OrigPC=EXC_VECTOR_SEL. Next state is FETCH.
- Reset asserted in any state, including mid-WAIT, returns to RESET immediately and clears the counter. No partial store completes after reset.

Optional Feature:
Macro CTRL_EXCEPTION_EN.
- Defined:
  - An invalid opcode in DECODE goes to EXC with Causa=0.
  - In R_WRITE (funct 0x20 or 0x22) and ADDI_WRITE, Overflow=1 forces EscreveReg=0 and the next state to EXC with Causa=1.
- Undefined:
  - The EXC state is unreachable, and EscreveEPC and Causa are tied to 0.
  - Invalid opcodes go to NOP, and Overflow is ignored.

Test Plan:
- Reset held for 3 cycles, then released -> State=0 with all outputs 0 during reset; State=1 with EscrevePC=1 on the next cycle.
- MEM_WAIT=3, add (op 0, funct 0x20) -> State sequence 1,2,2,2,3,4,5,6,1; EscreveReg=1 with RegDst=01 only in state 6.
- lw (op 0x23), MEM_WAIT=1 -> sequence 1,2,3,4,7,8,9,10,1; EscreveMDR=1 in state 9; MemparaReg=01 in state 10.
- sw (op 0x2B) with funct=0x23 garbage -> the FSM goes 7 to 11 (not LOAD_RD); EscreveMem pulses for exactly 1 cycle.
- jal (op 0x03) -> in state 16: RegDst=10, MemparaReg=11, OrigPC=10, EscrevePC=1, EscreveReg=1.
- With CTRL_EXCEPTION_EN: op 0x3F -> state 22 with Causa=0, EscreveEPC=1, OrigPC=11. addi with Overflow=1 in state 19 -> EscreveReg=0, next state 22 with Causa=1. Without the macro: op 0x3F -> state 20.
